// File: rtl/fwd_hazard_if.sv
// rtl/fwd_hazard_if.sv - DC/EX operand bus between the pipeline and the forwarding hazard unit
interface fwd_hazard_if #(
  parameter int WIDTH = 32,
  parameter int REGS  = 32,
  parameter int DEPTH = 3
);
  localparam int RW = $clog2(REGS);
  localparam int SW = $clog2(DEPTH + 1);

  logic                   issueValid;
  logic                   issueWrites;
  logic                   issueIsLoad;
  logic [RW-1:0]          issueRd;
  logic [RW-1:0]          rs1;
  logic [RW-1:0]          rs2;
  logic                   rs1Used;
  logic                   rs2Used;
  logic [WIDTH-1:0]       rf1;
  logic [WIDTH-1:0]       rf2;
  logic [DEPTH*WIDTH-1:0] stageResult;
  logic                   memStall;
  logic                   flush;
  logic                   stallOut;
  logic [SW-1:0]          fwd1Sel;
  logic [SW-1:0]          fwd2Sel;
  logic [WIDTH-1:0]       op1;
  logic [WIDTH-1:0]       op2;
  logic [31:0]            stallCycles;

  // pipeline side: presents the DC instruction and stage results
  modport master (
    output issueValid, issueWrites, issueIsLoad, issueRd, rs1, rs2, rs1Used, rs2Used,
           rf1, rf2, stageResult, memStall, flush,
    input  stallOut, fwd1Sel, fwd2Sel, op1, op2, stallCycles
  );

  // hazard unit side
  modport slave (
    input  issueValid, issueWrites, issueIsLoad, issueRd, rs1, rs2, rs1Used, rs2Used,
           rf1, rf2, stageResult, memStall, flush,
    output stallOut, fwd1Sel, fwd2Sel, op1, op2, stallCycles
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - in-flight writer tracking with EX/MM/WB bypass; HAZ_FWD_EN enables forwarding
module fwd_hazard_unit #(
  parameter int WIDTH            = 32,
  parameter int REGS             = 32,
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  fwd_hazard_if.slave bus
);
  localparam int RW = $clog2(REGS);
  localparam int SW = $clog2(DEPTH + 1);

  // entry k describes the instruction currently in stage k (0=EX)
  logic [DEPTH-1:0]         tab_valid;
  logic [DEPTH-1:0][RW-1:0] tab_rd;
  logic [DEPTH-1:0]         tab_load;
  logic [31:0]              stall_cnt;

  logic [RW-1:0]    src_rs   [2];
  logic             src_used [2];
  logic [WIDTH-1:0] src_rf   [2];
  logic [SW-1:0]    src_sel  [2];
  logic [WIDTH-1:0] src_op   [2];
  logic             src_haz  [2];
  logic             stall;

  assign src_rs[0]   = bus.rs1;
  assign src_rs[1]   = bus.rs2;
  assign src_used[0] = bus.rs1Used;
  assign src_used[1] = bus.rs2Used;
  assign src_rf[0]   = bus.rf1;
  assign src_rf[1]   = bus.rf2;

  // per-source lookup: youngest matching writer decides forward or hazard
  always_comb begin : lookup_comb
    logic hit;
    for (int s = 0; s < 2; s++) begin
      hit        = 1'b0;
      src_sel[s] = '0;
      src_haz[s] = 1'b0;
      src_op[s]  = (src_rs[s] == '0) ? '0 : src_rf[s];
      if (src_used[s] && (src_rs[s] != '0)) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (!hit && tab_valid[k] && (tab_rd[k] == src_rs[s])) begin
            hit = 1'b1;
`ifdef HAZ_FWD_EN
            if (!tab_load[k] || (k >= LOAD_READY_STAGE)) begin
              src_sel[s] = SW'(k + 1);
              src_op[s]  = bus.stageResult[k*WIDTH +: WIDTH];
            end else begin
              src_haz[s] = 1'b1;
            end
`else
            src_haz[s] = 1'b1;
`endif
          end
        end
      end
    end
  end

`ifndef HAZ_FWD_EN
  // without forwarding, load flags and stage results never reach the outputs
  localparam int lrs_unused = LOAD_READY_STAGE;
  logic unused_fwd;
  assign unused_fwd = ^{bus.stageResult, tab_load};
`endif

  // a squashed DC instruction never stalls
  assign stall = bus.issueValid & ~bus.flush & (src_haz[0] | src_haz[1]);

  assign bus.stallOut    = stall;
  assign bus.fwd1Sel     = src_sel[0];
  assign bus.fwd2Sel     = src_sel[1];
  assign bus.op1         = src_op[0];
  assign bus.op2         = src_op[1];
  assign bus.stallCycles = stall_cnt;

  // advance the tracking table with the pipeline; stall/flush enter a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tab_valid <= '0;
      tab_rd    <= '0;
      tab_load  <= '0;
    end else if (!bus.memStall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        tab_valid[k] <= tab_valid[k-1];
        tab_rd[k]    <= tab_rd[k-1];
        tab_load[k]  <= tab_load[k-1];
      end
      tab_valid[0] <= bus.issueValid & bus.issueWrites & (bus.issueRd != '0) & ~stall & ~bus.flush;
      tab_rd[0]    <= bus.issueRd;
      tab_load[0]  <= bus.issueIsLoad;
    end
  end

  // saturating count of stall cycles, frozen while MM is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && !bus.memStall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit against a pipeline-occupancy model
module tb_fwd_hazard_unit;
  localparam int DEPTH = 3;
  localparam int LRS   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_if #(.WIDTH(32), .REGS(32), .DEPTH(DEPTH)) bus ();

  fwd_hazard_unit #(.WIDTH(32), .REGS(32), .DEPTH(DEPTH), .LOAD_READY_STAGE(LRS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit v;
    int rd;
    bit ld;
  } instr_t;

  typedef struct {
    logic [31:0] st;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] cnt;
  } exp_t;

  instr_t          pipe[$];   // pipe[k] = writer occupying stage k
  exp_t            expq[$];
  longint unsigned m_cnt;
  int              n_chk = 0;
  int              n_fail = 0;

  function automatic void clear_pipe();
    pipe.delete();
    for (int k = 0; k < DEPTH; k++) pipe.push_back('{0, 0, 0});
  endfunction

  // a source is served by the youngest in-flight writer of that register
  function automatic void ref_src(input bit used, input int rs, input logic [31:0] rf,
                                  input logic [95:0] sr, output bit haz, output int sel,
                                  output logic [31:0] op);
    haz = 0;
    sel = 0;
    op  = (rs == 0) ? 32'd0 : rf;
    if (!used || rs == 0) return;
    for (int k = 0; k < pipe.size(); k++) begin
      if (pipe[k].v && pipe[k].rd == rs) begin
`ifdef HAZ_FWD_EN
        if (!pipe[k].ld || k >= LRS) begin
          sel = k + 1;
          op  = sr[k*32 +: 32];
        end else begin
          haz = 1;
        end
`else
        haz = 1;
`endif
        return;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // drive one DC cycle, predict its outputs, then advance the model to the next edge
  task automatic step(input bit iv, input bit iw, input bit il, input int rd,
                      input int r1, input bit u1, input int r2, input bit u2,
                      input bit ms, input bit fl, input bit rst);
    logic [31:0] f1, f2, o1, o2;
    logic [95:0] sr;
    bit          h1, h2, st;
    int          s1, s2;
    exp_t        e;
    @(posedge clk);
    #1;
    f1 = $urandom;
    f2 = $urandom;
    sr = {$urandom, $urandom, $urandom};
    rst_n           = !rst;
    bus.issueValid  = iv;
    bus.issueWrites = iw;
    bus.issueIsLoad = il;
    bus.issueRd     = rd[4:0];
    bus.rs1         = r1[4:0];
    bus.rs2         = r2[4:0];
    bus.rs1Used     = u1;
    bus.rs2Used     = u2;
    bus.rf1         = f1;
    bus.rf2         = f2;
    bus.stageResult = sr;
    bus.memStall    = ms;
    bus.flush       = fl;
    if (rst) begin
      clear_pipe();
      m_cnt = 0;
    end
    ref_src(u1, r1, f1, sr, h1, s1, o1);
    ref_src(u2, r2, f2, sr, h2, s2, o2);
    st = iv && !fl && (h1 || h2);
    e.st  = {31'd0, st};
    e.s1  = s1;
    e.s2  = s2;
    e.o1  = o1;
    e.o2  = o2;
    e.cnt = m_cnt[31:0];
    expq.push_back(e);
    if (!rst && !ms) begin
      pipe.push_front('{iv && iw && rd != 0 && !st && !fl, rd, il});
      void'(pipe.pop_back());
      if (st && m_cnt != 64'hFFFF_FFFF) m_cnt++;
    end
  endtask

  // monitor: compare whatever the DUT presents mid-cycle against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("stallOut", {31'd0, bus.stallOut}, e.st);
        chk("fwd1Sel", {30'd0, bus.fwd1Sel}, e.s1);
        chk("fwd2Sel", {30'd0, bus.fwd2Sel}, e.s2);
        chk("op1", bus.op1, e.o1);
        chk("op2", bus.op2, e.o2);
        chk("stallCycles", bus.stallCycles, e.cnt);
      end
    end
  end

  initial begin
    bit ms, fl, rs;
    clear_pipe();
    m_cnt = 0;
    bus.issueValid = 0; bus.issueWrites = 0; bus.issueIsLoad = 0; bus.issueRd = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.rs1Used = 0; bus.rs2Used = 0;
    bus.rf1 = '0; bus.rf2 = '0; bus.stageResult = '0; bus.memStall = 0; bus.flush = 0;

    // reset state, then ALU x5 forwarded from EX
    repeat (2) step(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    // load x7 consumed immediately: held until the load reaches WB
    step(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    // two writers of x3: youngest wins
    step(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 3, 1, 3, 1, 0, 0, 0);
    // x0 destination is never tracked, x0 source reads zero
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    // load-use under memStall, then flush, then reset mid-stream
    step(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 9, 1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 9, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 4, 9, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 4, 1, 9, 1, 0, 0, 1);
    step(1, 0, 0, 0, 4, 1, 9, 1, 0, 0, 0);
    // x5 with no forwarding path stalls through WB
    step(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);

    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      ms = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           $urandom_range(0, 7), $urandom_range(0, 1), ms, fl, rs);
    end

    repeat (3) @(posedge clk);
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions never compared, expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
